gpu_tex_fill_arbiter: RTL and testbench
=======================================

# gpu_tex_fill_arbiter

Arbitrates the GPU's single VRAM read port between two requesters: texture cache line fills (raised by the pixel pipeline on a texture cache miss) and CLUT cache loads (raised at primitive setup). It sequences each fill as one burst: request, acknowledge, data beats, cache writes, completion pulse. It sits between the pixel pipeline / cache arrays and the VRAM memory controller.

## Interface
- No parameters. Word = 64 bits = 4 VRAM halfwords; VRAM word address is 17 bits.
- clk  in  1  single clock, all logic on rising edge
- i_nrst  in  1  reset, asynchronous, active-low
- i_texReq  in  1  level; texture line fill wanted; held until completion seen
- i_texAdr  in  17  word address of texture line; sampled at grant
- o_texWrite  out  1  write strobe into texture cache
- o_texWrAdr  out  17  line address for write (= latched i_texAdr)
- o_texDone  out  1  one-cycle pulse, fill finished
- i_clutReq  in  1  level; CLUT load wanted; held until completion seen
- i_clutAdr  in  17  word address of CLUT start; sampled at grant
- i_clut8bpp  in  1  1: 256 entries = 64 words; 0: 16 entries = 4 words; sampled at grant
- o_clutWrite  out  1  write strobe into CLUT cache
- o_clutWrIdx  out  6  word index within CLUT (0..63)
- o_clutDone  out  1  one-cycle pulse, load finished
- o_wrData  out  64  data for either cache write (shared)
- o_memReq  out  1  burst request to memory controller
- o_memAdr  out  17  burst start word address
- o_memLenM1  out  6  burst length minus 1 (0 = 1 word, 63 = 64 words)
- i_memAck  in  1  memory accepted request this cycle
- i_memValid  in  1  one data beat valid this cycle
- i_memData  in  64  beat data
- o_busy  out  1  state != IDLE
- o_protoErr  out  1  sticky; beat received outside DATA state

## Operation
- States: IDLE, REQ, DATA, DONE, HOLD.
- IDLE: if i_clutReq -> grant CLUT (priority over texture); else if i_texReq -> grant TEX; latch owner, address, length (TEX: 0; CLUT: 63 or 3); go REQ. Neither -> stay.
- REQ: o_memReq=1 with o_memAdr/o_memLenM1 stable; on i_memAck -> DATA, beat counter = 0.
- DATA: each i_memValid beat -> next cycle: owner's write strobe=1, o_wrData=beat, o_texWrAdr = latched addr or o_clutWrIdx = beat counter; counter +1. Beat with counter == length -> DONE.
- DONE: one cycle, owner's done pulse=1 (last write occurs in this same cycle); -> HOLD.
- HOLD: one cycle, both requests ignored (requester drops level on cycle after done pulse); -> IDLE.
- i_memValid outside DATA: ignored for writes, sets o_protoErr (cleared only by reset).
- Grant inputs sampled only in IDLE; changes of address/format while busy have no effect.
- Counter 6 bits; no wrap possible (max length 64 = counter 63).

## Timing
- Reset (async, immediate): state IDLE; all outputs 0, o_wrData 0, counter 0, o_protoErr 0.
- Request seen in IDLE at cycle t -> o_memReq=1 at t+1. Ack at cycle a (memReq may be combinationally acked at t+1) -> DATA at a+1; o_memReq low at a+1.
- Beat at cycle b -> write strobe at b+1. Last beat at cycle L -> DONE at L+1 (write + done same cycle), HOLD at L+2, IDLE at L+3; next grant issues o_memReq at L+4.
- Texture fill, ack at t+1, beat at t+3: write+done at t+4.
- Beats may be non-consecutive; gaps keep state DATA.
- Simultaneous i_texReq and i_clutReq in IDLE: CLUT served first; TEX served after CLUT HOLD.
- Reset asserted mid-burst: no completion pulse; after release requesters must re-present.

## Test plan
- Single TEX fill: i_texReq, adr 0x01234; ack immediately, beat 0xDEADBEEF_00112233 two cycles later -> o_memAdr 0x01234, LenM1 0; o_texWrite with that data and o_texDone same cycle; req dropped, o_busy low 2 cycles later.
- CLUT 4bpp at 0x1F000: 4 beats with gaps -> LenM1 3, o_clutWrIdx 0,1,2,3, o_clutDone with idx 3 write.
- CLUT 8bpp: 64 consecutive beats -> idx 0..63, one done pulse, no wrap, no extra write.
- Both requests raised same cycle: CLUT burst first (LenM1 3), TEX request starts exactly 4 cycles after CLUT last beat.
- Held i_texReq one cycle past o_texDone -> no second fill issued (HOLD).
- Beat injected in IDLE -> no write strobe, o_protoErr=1 until reset; reset pulse during DATA -> all outputs 0 immediately, no done pulse.

Source files
------------

// File: rtl/gpu_tex_fill_arbiter.sv
// Arbitrates the VRAM read port between texture line fills and CLUT loads (CLUT wins ties).
// Latency: request in IDLE -> o_memReq next cycle; beat -> cache write next cycle; 3 idle cycles after last beat.
// Backpressure: holds o_memReq until i_memAck; beats may arrive with gaps and are never refused.
module gpu_tex_fill_arbiter (
    input  logic        clk,
    input  logic        i_nrst,
    input  logic        i_texReq,
    input  logic [16:0] i_texAdr,
    output logic        o_texWrite,
    output logic [16:0] o_texWrAdr,
    output logic        o_texDone,
    input  logic        i_clutReq,
    input  logic [16:0] i_clutAdr,
    input  logic        i_clut8bpp,
    output logic        o_clutWrite,
    output logic [5:0]  o_clutWrIdx,
    output logic        o_clutDone,
    output logic [63:0] o_wrData,
    output logic        o_memReq,
    output logic [16:0] o_memAdr,
    output logic [5:0]  o_memLenM1,
    input  logic        i_memAck,
    input  logic        i_memValid,
    input  logic [63:0] i_memData,
    output logic        o_busy,
    output logic        o_protoErr
);

    typedef enum logic [2:0] {IDLE, REQ, DATA, DONE, HOLD} state_t;

    state_t      state;
    logic        ownerClut;
    logic [16:0] latAdr;
    logic [5:0]  lenM1;
    logic [5:0]  beatCnt;
    logic        texWrite;
    logic        clutWrite;
    logic        texDone;
    logic        clutDone;
    logic [5:0]  clutWrIdx;
    logic [63:0] wrData;
    logic        memReq;
    logic        protoErr;

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state     <= IDLE;
            ownerClut <= 1'b0;
            latAdr    <= '0;
            lenM1     <= '0;
            beatCnt   <= '0;
            texWrite  <= 1'b0;
            clutWrite <= 1'b0;
            texDone   <= 1'b0;
            clutDone  <= 1'b0;
            clutWrIdx <= '0;
            wrData    <= '0;
            memReq    <= 1'b0;
            protoErr  <= 1'b0;
        end else begin
            texWrite  <= 1'b0;
            clutWrite <= 1'b0;
            texDone   <= 1'b0;
            clutDone  <= 1'b0;

            // A beat with no burst outstanding means the controller and arbiter disagree.
            if (i_memValid && state != DATA)
                protoErr <= 1'b1;

            case (state)
                IDLE: begin
                    if (i_clutReq) begin
                        ownerClut <= 1'b1;
                        latAdr    <= i_clutAdr;
                        lenM1     <= i_clut8bpp ? 6'd63 : 6'd3;
                        memReq    <= 1'b1;
                        state     <= REQ;
                    end else if (i_texReq) begin
                        ownerClut <= 1'b0;
                        latAdr    <= i_texAdr;
                        lenM1     <= 6'd0;
                        memReq    <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (i_memAck) begin
                        memReq  <= 1'b0;
                        beatCnt <= 6'd0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (i_memValid) begin
                        wrData    <= i_memData;
                        texWrite  <= !ownerClut;
                        clutWrite <= ownerClut;
                        if (ownerClut)
                            clutWrIdx <= beatCnt;
                        beatCnt <= beatCnt + 6'd1;
                        // Last write and completion pulse share a cycle.
                        if (beatCnt == lenM1) begin
                            texDone  <= !ownerClut;
                            clutDone <= ownerClut;
                            state    <= DONE;
                        end
                    end
                end
                DONE:    state <= HOLD;
                HOLD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_texWrite  = texWrite;
    assign o_texWrAdr  = latAdr;
    assign o_texDone   = texDone;
    assign o_clutWrite = clutWrite;
    assign o_clutWrIdx = clutWrIdx;
    assign o_clutDone  = clutDone;
    assign o_wrData    = wrData;
    assign o_memReq    = memReq;
    assign o_memAdr    = latAdr;
    assign o_memLenM1  = lenM1;
    assign o_busy      = (state != IDLE);
    assign o_protoErr  = protoErr;

endmodule

// File: tb/tb_gpu_tex_fill_arbiter.sv
// Scoreboard bench for gpu_tex_fill_arbiter: expected cache writes queued as beats are driven.
module tb_gpu_tex_fill_arbiter;

    logic        clk = 1'b0;
    logic        i_nrst;
    logic        i_texReq;
    logic [16:0] i_texAdr;
    logic        o_texWrite;
    logic [16:0] o_texWrAdr;
    logic        o_texDone;
    logic        i_clutReq;
    logic [16:0] i_clutAdr;
    logic        i_clut8bpp;
    logic        o_clutWrite;
    logic [5:0]  o_clutWrIdx;
    logic        o_clutDone;
    logic [63:0] o_wrData;
    logic        o_memReq;
    logic [16:0] o_memAdr;
    logic [5:0]  o_memLenM1;
    logic        i_memAck;
    logic        i_memValid;
    logic [63:0] i_memData;
    logic        o_busy;
    logic        o_protoErr;

    always #5 clk = ~clk;

    gpu_tex_fill_arbiter dut (
        .clk(clk), .i_nrst(i_nrst),
        .i_texReq(i_texReq), .i_texAdr(i_texAdr),
        .o_texWrite(o_texWrite), .o_texWrAdr(o_texWrAdr), .o_texDone(o_texDone),
        .i_clutReq(i_clutReq), .i_clutAdr(i_clutAdr), .i_clut8bpp(i_clut8bpp),
        .o_clutWrite(o_clutWrite), .o_clutWrIdx(o_clutWrIdx), .o_clutDone(o_clutDone),
        .o_wrData(o_wrData),
        .o_memReq(o_memReq), .o_memAdr(o_memAdr), .o_memLenM1(o_memLenM1),
        .i_memAck(i_memAck), .i_memValid(i_memValid), .i_memData(i_memData),
        .o_busy(o_busy), .o_protoErr(o_protoErr)
    );

    typedef struct packed {
        logic        clut;
        logic [16:0] key;
        logic [63:0] dat;
        logic        last;
    } exp_t;

    exp_t sbq[$];
    exp_t monExp;
    int   nChecks = 0;
    int   nErrors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every cache write must match the oldest outstanding beat.
    always @(negedge clk) begin
        if (o_texWrite || o_clutWrite) begin
            if (sbq.size() == 0) begin
                check("unexpectedWrite", {o_texWrite, o_clutWrite}, 0);
            end else begin
                monExp = sbq.pop_front();
                check("wrOwner", {o_texWrite, o_clutWrite}, {!monExp.clut, monExp.clut});
                check("wrKey", monExp.clut ? {11'd0, o_clutWrIdx} : o_texWrAdr, monExp.key);
                check("wrData", o_wrData, monExp.dat);
                check("donePulse", {o_texDone, o_clutDone},
                      {!monExp.clut && monExp.last, monExp.clut && monExp.last});
            end
        end else if (o_texDone || o_clutDone) begin
            check("doneNoWrite", {o_texDone, o_clutDone}, 0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait for the grant, ack it, then deliver the burst with `gap` idle cycles before each beat.
    // Returns on the negedge where the last write and done pulse are visible.
    task automatic serveBurst(input bit clut, input logic [16:0] adr, input bit b8,
                              input int gap, input logic [63:0] d0);
        int n;
        n = clut ? (b8 ? 64 : 4) : 1;
        for (int i = 0; i < 20 && !o_memReq; i++) tick();
        check("memReq", o_memReq, 1);
        check("memAdr", o_memAdr, adr);
        check("memLenM1", o_memLenM1, n - 1);
        i_memAck = 1'b1;
        tick();
        i_memAck = 1'b0;
        check("memReqDrop", o_memReq, 0);
        for (int b = 0; b < n; b++) begin
            for (int g = 0; g < gap; g++) tick();
            i_memValid = 1'b1;
            i_memData  = (b == 0) ? d0 : {$urandom, $urandom};
            sbq.push_back('{clut, clut ? 17'(b) : adr, i_memData, (b == n - 1)});
            tick();
            i_memValid = 1'b0;
        end
    endtask

    initial begin
        i_nrst = 1'b1;
        i_texReq = 1'b0;  i_texAdr = '0;
        i_clutReq = 1'b0; i_clutAdr = '0; i_clut8bpp = 1'b0;
        i_memAck = 1'b0;  i_memValid = 1'b0; i_memData = '0;
        #2 i_nrst = 1'b0;
        repeat (2) tick();
        check("rstBusy", o_busy, 0);
        check("rstMemReq", o_memReq, 0);
        check("rstProtoErr", o_protoErr, 0);
        check("rstWrData", o_wrData, 0);
        check("rstStrobes", {o_texWrite, o_clutWrite, o_texDone, o_clutDone}, 0);
        i_nrst = 1'b1;
        tick();

        // Single texture fill: beat two cycles after ack.
        i_texReq = 1'b1;
        i_texAdr = 17'h01234;
        serveBurst(1'b0, 17'h01234, 1'b0, 1, 64'hDEADBEEF_00112233);
        i_texReq = 1'b0;
        i_texAdr = 17'h1FFFF;
        tick();
        check("texHoldBusy", o_busy, 1);
        tick();
        check("texIdleBusy", o_busy, 0);
        check("texSbEmpty", sbq.size(), 0);

        // CLUT 4bpp with gaps; format/address changes after grant have no effect.
        i_clutReq  = 1'b1;
        i_clutAdr  = 17'h1F000;
        i_clut8bpp = 1'b0;
        tick();
        i_clut8bpp = 1'b1;
        i_clutAdr  = 17'h00055;
        serveBurst(1'b1, 17'h1F000, 1'b0, 2, {$urandom, $urandom});
        i_clutReq = 1'b0;
        repeat (2) tick();
        check("clut4SbEmpty", sbq.size(), 0);

        // CLUT 8bpp, 64 back-to-back beats.
        i_clutReq  = 1'b1;
        i_clutAdr  = 17'h0AB00;
        i_clut8bpp = 1'b1;
        serveBurst(1'b1, 17'h0AB00, 1'b1, 0, {$urandom, $urandom});
        i_clutReq = 1'b0;
        repeat (2) tick();
        check("clut8SbEmpty", sbq.size(), 0);
        check("clut8Busy", o_busy, 0);

        // Both requests together: CLUT first, TEX grant exactly 4 cycles after the last CLUT beat.
        i_clutReq  = 1'b1;
        i_clutAdr  = 17'h1F100;
        i_clut8bpp = 1'b0;
        i_texReq   = 1'b1;
        i_texAdr   = 17'h00777;
        serveBurst(1'b1, 17'h1F100, 1'b0, 0, {$urandom, $urandom});
        i_clutReq = 1'b0;
        tick();
        check("arbHoldReq", o_memReq, 0);
        tick();
        check("arbIdleReq", o_memReq, 0);
        tick();
        check("arbTexReq", o_memReq, 1);
        serveBurst(1'b0, 17'h00777, 1'b0, 0, {$urandom, $urandom});

        // Keep texReq through the HOLD cycle: no second fill.
        tick();
        i_texReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("noRefill", o_memReq, 0);
        end
        check("arbSbEmpty", sbq.size(), 0);

        // Stray beat in IDLE.
        i_memValid = 1'b1;
        i_memData  = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        i_memValid = 1'b0;
        check("protoErrSet", o_protoErr, 1);
        repeat (3) tick();
        check("protoErrSticky", o_protoErr, 1);

        // Reset in the middle of an 8bpp CLUT load.
        i_clutReq  = 1'b1;
        i_clutAdr  = 17'h00200;
        i_clut8bpp = 1'b1;
        for (int i = 0; i < 20 && !o_memReq; i++) tick();
        check("midMemReq", o_memReq, 1);
        i_memAck = 1'b1;
        tick();
        i_memAck = 1'b0;
        for (int b = 0; b < 3; b++) begin
            i_memValid = 1'b1;
            i_memData  = {$urandom, $urandom};
            sbq.push_back('{1'b1, 17'(b), i_memData, 1'b0});
            tick();
            i_memValid = 1'b0;
        end
        #2 i_nrst = 1'b0;
        #1;
        check("midRstBusy", o_busy, 0);
        check("midRstProtoErr", o_protoErr, 0);
        check("midRstWrData", o_wrData, 0);
        check("midRstIdx", o_clutWrIdx, 0);
        check("midRstStrobes", {o_texWrite, o_clutWrite, o_texDone, o_clutDone}, 0);
        check("midRstMem", {o_memReq, o_memAdr, o_memLenM1}, 0);
        i_clutReq = 1'b0;
        tick();
        i_nrst = 1'b1;
        repeat (5) tick();
        check("postRstBusy", o_busy, 0);
        check("postRstMemReq", o_memReq, 0);
        check("postRstSbEmpty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
